prio_enc_disp: RTL and testbench
================================

# prio_enc_disp

Parametrised, registered priority encoder with a time-multiplexed hexadecimal seven-segment display driver. It samples an N-bit request vector, reports the index of the highest set bit with a valid flag and a change pulse, and scans the index across one or more hex digits. It sits between the board switch/button inputs and the LED/seven-segment outputs of the peripheral test designs.

## Interface
Parameters:
- N, 16, request width; legal range 2..256.
- SCAN_DIV, 1000, clock cycles each digit is lit; must be ≥1.
- Derived, not overridable: W = max(1, $clog2(N)) index width; D = ceil(W/4) digit count.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- en  in  1  encoder enable; asynchronous to clk (switch).
- req  in  N  request vector; asynchronous to clk; bit N-1 has highest priority.
- idx  out  W  index of the highest set request bit.
- valid  out  1  high when enabled and at least one request bit is set.
- changed  out  1  one-cycle pulse when {valid, idx} changes value.
- en_led  out  1  synchronised copy of en.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  D  digit enables, active-low, one-hot-low while scanning.

## Operation
- Synchroniser: two flops each on req and en, giving req_s and en_s. en_led = en_s.
- Encoder register, updated every cycle:
  - en_s=1: valid ← |req_s; idx ← highest i with req_s[i]=1, or 0 if req_s=0.
  - en_s=0: valid ← 0; idx holds its last value.
- changed ← 1 for exactly one cycle after any cycle in which the new {valid, idx} differs from the registered one; otherwise 0.
- Display content per digit k (k=0 least significant nibble, zero-extended to 4·D bits):
  - en_s=0: blank (all segments off).
  - en_s=1, valid=0: dash (segment g only).
  - valid=1: hex glyph of idx[4k+3:4k], using 0-9 and A, b, C, d, E, F.
- Scanner: a counter runs 0..SCAN_DIV-1. At wrap, the digit pointer advances by one and wraps from D-1 to 0. When D=1, the pointer stays at 0 and an[0] is permanently 0 after reset. an and seg are registered together, so they always refer to the same digit.

## Timing
- Reset, on the first clk edge with rst_n=0:
  - idx=0, valid=0, changed=0, en_led=0.
  - seg=7'b1111111 (blank); an = all ones.
  - Scan counter=0, pointer=0; synchroniser flops=0.
- Reset asserted mid-scan or mid-change: all state returns to the reset values on that edge. No changed pulse is produced by reset or by leaving reset.
- Latency, req/en to idx/valid: 3 cycles (2 synchroniser + 1 encoder register). changed follows idx/valid by 1 cycle. seg/an reflect a new idx within 1 cycle of the idx update, on whichever digit is currently lit.
- First digit enable: after reset release, an for digit 0 goes low on the first edge and seg shows digit 0 on that same edge.
- Simultaneous events:
  - If en falls in the same cycle as a req change, the en path wins: valid=0 and idx holds.
  - A req glitch shorter than one cycle may or may not be captured; no further filtering is performed.
- Wrap: with SCAN_DIV=1, the pointer advances every cycle.

## Structure
- Package enc_disp_pkg holds:
  - function hex7(input [3:0]) returning the active-high {g..a} glyph (0→0111111, 1→0000110, 8→1111111, F→1110001, standard hex font);
  - constants SEG_BLANK and SEG_DASH (active-high 0000000 and 1000000);
  - function digits(W).
- Output inversion to active-low happens once, at the seg register.
- Sub-module seg_scan, parameterised on D and SCAN_DIV, takes a 4·D-bit value plus a blank and a dash control and produces seg/an. The encoder and synchronisers stay in the top level.

## Test plan
- Reset with N=16, SCAN_DIV=4, en=1, req=0:
  - During reset: idx=0, valid=0, seg=7'h7F, an=1'b1.
  - After release: seg=7'b0111111 (dash, active-low), an=0.
- N=16, en=1, req=16'h0000→16'h0900:
  - 3 cycles later idx=11, valid=1; one cycle after that changed=1 for exactly 1 cycle.
  - Following cycle: seg=~7'b1111100 (b).
- Priority sweep, N=16: walk a one from bit 0 to bit 15 with all lower bits also set → idx equals the walking position each time; changed pulses once per step.
- en drop, N=16, req=16'h8000 stable, en 1→0:
  - 3 cycles later valid=0, idx holds 15, changed pulses once.
  - Display blank (seg=7'h7F), en_led=0.
- Scan, N=256 (D=2), SCAN_DIV=4, req=8'h00 with bit 0xA5 set (index 165), en=1:
  - an alternates 2'b10/2'b01 every 4 cycles.
  - seg shows 5 on digit 0 and A on digit 1.
  - Reset asserted mid-period returns an to 2'b11 and the counter to 0 on that edge.

Source files
------------

// File: rtl/enc_disp_pkg.sv
// Shared glyph table and sizing helpers for the priority encoder display.
package enc_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int digits(input int w);
    return (w + 3) / 4;
  endfunction

  // Active-high {g,f,e,d,c,b,a}; b and d are lower case so they differ from 8 and 0.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed hex display scanner; seg and an are registered together
// so the lit digit and its glyph always belong to the same nibble.
module seg_scan
  import enc_disp_pkg::*;
#(
  parameter int D        = 1,
  parameter int SCAN_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4*D-1:0] val,
  input  logic           blank,
  input  logic           dash,
  output logic [6:0]     seg,
  output logic [D-1:0]   an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  always_comb begin
    nib = val[4*ptr +: 4];
    if (blank)     glyph = SEG_BLANK;
    else if (dash) glyph = SEG_DASH;
    else           glyph = hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
      seg <= '1;
      an  <= '1;
    end else begin
      seg <= ~glyph;
      an  <= ~(D'(1) << ptr);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_disp.sv
// Registered priority encoder on a synchronised request vector, with change
// pulse and a scanned hex display of the winning index.
module prio_enc_disp
  import enc_disp_pkg::*;
#(
  parameter int N        = 16,
  parameter int SCAN_DIV = 1000,
  localparam int W       = idx_width(N),
  localparam int D       = digits(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic         changed,
  output logic         en_led,
  output logic [6:0]   seg,
  output logic [D-1:0] an
);

  localparam int VW = 4 * D;

  logic [N-1:0]  req_p0, req_p1;
  logic          en_p0, en_p1;
  logic [W-1:0]  idx_p2, idx_p3;
  logic          vld_p2, vld_p3;
  logic          chg_p3;
  logic [W-1:0]  hi_idx;
  logic [VW-1:0] disp_val;

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_p1[i]) hi_idx = W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_p0 <= '0;
      req_p1 <= '0;
      en_p0  <= 1'b0;
      en_p1  <= 1'b0;
      idx_p2 <= '0;
      vld_p2 <= 1'b0;
      idx_p3 <= '0;
      vld_p3 <= 1'b0;
      chg_p3 <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronisers on the asynchronous switch inputs
      req_p0 <= req;
      req_p1 <= req_p0;
      en_p0  <= en;
      en_p1  <= en_p0;
      // p2: encoder register; a dropped enable clears valid but freezes idx
      vld_p2 <= en_p1 & (|req_p1);
      if (en_p1) idx_p2 <= hi_idx;
      // p3: compare against the previous encoder value for the change pulse
      idx_p3 <= idx_p2;
      vld_p3 <= vld_p2;
      chg_p3 <= ({vld_p2, idx_p2} != {vld_p3, idx_p3});
    end
  end

  assign idx      = idx_p2;
  assign valid    = vld_p2;
  assign changed  = chg_p3;
  assign en_led   = en_p1;
  assign disp_val = VW'(idx_p2);

  seg_scan #(
    .D        (D),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (disp_val),
    .blank (~en_p1),
    .dash  (~vld_p2),
    .seg   (seg),
    .an    (an)
  );

endmodule

// File: tb/tb_prio_enc_disp.sv
// Bench for prio_enc_disp: directed sequences, a vector table and a
// randomized run against a cycle-level reference model (N=16), plus scan checks (N=256).
module tb_prio_enc_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en16, en256;
  logic [15:0] req16;
  logic [255:0] req256;

  logic [3:0]  idx16;
  logic        valid16, changed16, en_led16;
  logic [6:0]  seg16;
  logic [0:0]  an16;
  logic [7:0]  idx256;
  logic        valid256, changed256, en_led256;
  logic [6:0]  seg256;
  logic [1:0]  an256;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_enc_disp #(.N(16), .SCAN_DIV(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .req(req16),
    .idx(idx16), .valid(valid16), .changed(changed16), .en_led(en_led16),
    .seg(seg16), .an(an16)
  );

  prio_enc_disp #(.N(256), .SCAN_DIV(4)) dut256 (
    .clk(clk), .rst_n(rst_n), .en(en256), .req(req256),
    .idx(idx256), .valid(valid256), .changed(changed256), .en_led(en_led256),
    .seg(seg256), .an(an256)
  );

  // Active-high hex font {g..a}
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state for the N=16 instance
  logic        h_en [2];
  logic [15:0] h_req [2];
  int          m_idx, m_idx_d;
  logic        m_vld, m_vld_d, m_chg, m_en_led;
  logic [6:0]  m_seg;
  logic        m_an;

  function automatic int top_bit(input int r);
    return (r == 0) ? 0 : $clog2(r + 1) - 1;
  endfunction

  task automatic model_edge();
    logic s_en;
    int   s_req;
    if (!rst_n) begin
      h_en[0] = 0; h_en[1] = 0; h_req[0] = '0; h_req[1] = '0;
      m_idx = 0; m_idx_d = 0; m_vld = 0; m_vld_d = 0; m_chg = 0;
      m_seg = 7'h7F; m_an = 1'b1; m_en_led = 0;
    end else begin
      s_en  = h_en[1];
      s_req = int'(h_req[1]);
      m_an  = 1'b0;
      if (!s_en)      m_seg = 7'h7F;
      else if (m_vld) m_seg = ~font[m_idx];
      else            m_seg = ~7'h40;
      m_chg   = (m_vld != m_vld_d) || (m_idx != m_idx_d);
      m_vld_d = m_vld;
      m_idx_d = m_idx;
      m_vld   = s_en && (s_req != 0);
      if (s_en) m_idx = top_bit(s_req);
      h_en[1] = h_en[0]; h_req[1] = h_req[0];
      h_en[0] = en16;    h_req[0] = req16;
      m_en_led = h_en[1];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cmp_model();
    chk("rnd_idx", 32'(idx16), 32'(m_idx));
    chk("rnd_valid", 32'(valid16), 32'(m_vld));
    chk("rnd_changed", 32'(changed16), 32'(m_chg));
    chk("rnd_seg", 32'(seg16), 32'(m_seg));
    chk("rnd_an", 32'(an16), 32'(m_an));
    chk("rnd_en_led", 32'(en_led16), 32'(m_en_led));
  endtask

  typedef struct {
    logic        en;
    logic [15:0] req;
    int          idx;
    logic        vld;
    logic [6:0]  seg;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int pulses;
    int dig;
    rst_n = 1'b0; en16 = 1'b1; req16 = '0; en256 = 1'b0; req256 = '0;

    tbl[0]  = '{1'b1, 16'h0000, 0,  1'b0, 7'h3F};
    tbl[1]  = '{1'b1, 16'h0900, 11, 1'b1, 7'h03};
    tbl[2]  = '{1'b1, 16'h0001, 0,  1'b1, 7'h40};
    tbl[3]  = '{1'b1, 16'h8000, 15, 1'b1, 7'h0E};
    tbl[4]  = '{1'b0, 16'h0003, 15, 1'b0, 7'h7F};
    tbl[5]  = '{1'b1, 16'h00F0, 7,  1'b1, 7'h78};
    tbl[6]  = '{1'b1, 16'h0123, 8,  1'b1, 7'h00};
    tbl[7]  = '{1'b1, 16'h0020, 5,  1'b1, 7'h12};
    tbl[8]  = '{1'b1, 16'h0400, 10, 1'b1, 7'h08};
    tbl[9]  = '{1'b0, 16'hFFFF, 10, 1'b0, 7'h7F};
    tbl[10] = '{1'b1, 16'h1000, 12, 1'b1, 7'h46};
    tbl[11] = '{1'b1, 16'h2000, 13, 1'b1, 7'h21};
    tbl[12] = '{1'b1, 16'h4000, 14, 1'b1, 7'h06};
    tbl[13] = '{1'b1, 16'h0004, 2,  1'b1, 7'h24};

    // Reset state
    step(); step();
    chk("rst_idx", 32'(idx16), 0);
    chk("rst_valid", 32'(valid16), 0);
    chk("rst_changed", 32'(changed16), 0);
    chk("rst_seg", 32'(seg16), 32'h7F);
    chk("rst_an", 32'(an16), 1);
    chk("rst_en_led", 32'(en_led16), 0);
    rst_n = 1'b1;
    step();
    chk("first_an", 32'(an16), 0);
    pulses = int'(changed16);
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(changed16);
    end
    chk("release_dash", 32'(seg16), 32'h3F);
    chk("release_no_pulse", 32'(pulses), 0);

    // 0000 -> 0900
    req16 = 16'h0900;
    step(); step(); step();
    chk("b_idx", 32'(idx16), 11);
    chk("b_valid", 32'(valid16), 1);
    chk("b_chg_early", 32'(changed16), 0);
    step();
    chk("b_chg", 32'(changed16), 1);
    chk("b_seg", 32'(seg16), 32'h03);
    step();
    chk("b_chg_end", 32'(changed16), 0);

    // Priority sweep with lower bits filled
    for (int p = 0; p < 16; p++) begin
      req16 = 16'((32'd1 << (p + 1)) - 1);
      pulses = 0;
      for (int s = 0; s < 5; s++) begin
        step();
        pulses += int'(changed16);
      end
      chk("sweep_idx", 32'(idx16), 32'(p));
      chk("sweep_pulses", 32'(pulses), 1);
    end

    // Enable drop with a stable request
    req16 = 16'h8000;
    step(); step(); step(); step(); step();
    en16 = 1'b0;
    pulses = 0;
    step(); step();
    chk("drop_valid_held", 32'(valid16), 1);
    step();
    chk("drop_valid", 32'(valid16), 0);
    chk("drop_idx", 32'(idx16), 15);
    for (int s = 0; s < 3; s++) begin
      step();
      pulses += int'(changed16);
    end
    chk("drop_pulses", 32'(pulses), 1);
    chk("drop_seg", 32'(seg16), 32'h7F);
    chk("drop_en_led", 32'(en_led16), 0);

    // Vector table
    foreach (tbl[i]) begin
      en16  = tbl[i].en;
      req16 = tbl[i].req;
      for (int s = 0; s < 5; s++) step();
      chk("tbl_idx", 32'(idx16), 32'(tbl[i].idx));
      chk("tbl_valid", 32'(valid16), 32'(tbl[i].vld));
      chk("tbl_seg", 32'(seg16), 32'(tbl[i].seg));
      chk("tbl_an", 32'(an16), 0);
      chk("tbl_en_led", 32'(en_led16), 32'(tbl[i].en));
    end

    // Two-digit scan on N=256, index 0xA5
    en256 = 1'b1;
    req256[165] = 1'b1;
    rst_n = 1'b0;
    step();
    chk("scan_rst_an", 32'(an256), 32'h3);
    chk("scan_rst_seg", 32'(seg256), 32'h7F);
    rst_n = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      dig = ((k - 1) / 4) % 2;
      chk("scan_an", 32'(an256), (dig == 0) ? 32'h2 : 32'h1);
      if (k >= 8) chk("scan_seg", 32'(seg256), (dig == 0) ? 32'h12 : 32'h08);
    end
    chk("scan_idx", 32'(idx256), 165);
    chk("scan_valid", 32'(valid256), 1);
    chk("scan_changed", 32'(changed256), 0);
    chk("scan_en_led", 32'(en_led256), 1);
    rst_n = 1'b0;
    step();
    chk("midrst_an", 32'(an256), 32'h3);
    chk("midrst_idx", 32'(idx256), 0);
    chk("midrst_valid", 32'(valid256), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      dig = ((k - 1) / 4) % 2;
      chk("midrst_scan_an", 32'(an256), (dig == 0) ? 32'h2 : 32'h1);
    end

    // Randomized run against the model
    for (int it = 0; it < 700; it++) begin
      int hold;
      rst_n = ($urandom_range(0, 49) != 0);
      en16  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: req16 = '0;
        1: req16 = 16'(32'd1 << $urandom_range(0, 15));
        2: req16 = 16'($urandom);
        default: req16 = 16'($urandom >> $urandom_range(16, 31));
      endcase
      hold = $urandom_range(1, 4);
      for (int s = 0; s < hold; s++) begin
        step();
        cmp_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
